// File: rtl/multicycle_ctrl.sv
// Main sequencer for the RISC-V multicycle core: a Moore FSM that walks each
// instruction through fetch/decode/execute/memory/writeback and drives the datapath.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state;

  logic legal_op;
  assign legal_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;  // terminal states and unused codes 11-15
      endcase
    end
  end

  // Reset presents FETCH selects but with every enable held low, so an
  // instruction aborted mid-flight cannot write anything.
  state_t cur;
  logic   pc_update, branch, ir_write, mem_write, reg_write, done;
  aluop_t alu_op;

  always_comb begin
    cur       = reset ? S_FETCH : state;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    alu_op    = ALUOP_ADD;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (cur)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        done    = ~legal_op;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7b5; addi ignores that bit.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite   = ~reset & (pc_update | (branch & Zero));
  assign IRWrite   = ~reset & ir_write;
  assign MemWrite  = ~reset & mem_write;
  assign RegWrite  = ~reset & reg_write;
  assign InstrDone = ~reset & done;
  assign State     = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected state walk and per-state control values, then compared cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .InstrDone(InstrDone), .State(State)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int pcw, adr, memw, irw, res, srca, srcb, regw, imm, alu, done;
  } ctl_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // State walk of a whole instruction, FETCH through its last state.
  function automatic void walk(input logic [6:0] o, output int seq[$]);
    case (o)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 8};
      IT:      seq = '{0, 1, 7, 8};
      BQ:      seq = '{0, 1, 9};
      JL:      seq = '{0, 1, 10, 8};
      default: seq = '{0, 1};
    endcase
  endfunction

  function automatic int alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == RT && f7) ? 1 : 0;
    if (f3 == 3'b010) return 5;
    if (f3 == 3'b110) return 3;
    if (f3 == 3'b111) return 2;
    return 0;
  endfunction

  function automatic ctl_t expect_ctl(input int s, input logic [6:0] o, input logic [2:0] f3,
                                      input logic f7, input logic z, input logic last);
    ctl_t c = '{default: 0};
    c.imm = (o == SW) ? 1 : (o == BQ) ? 2 : (o == JL) ? 3 : 0;
    // every instruction except a bare FETCH finishes in its last state
    c.done = (last && s != 0) ? 1 : 0;
    case (s)
      0:  begin c.irw = 1; c.srcb = 2; c.res = 2; c.pcw = 1; end
      1:  begin c.srca = 1; c.srcb = 1; end
      2:  begin c.srca = 2; c.srcb = 1; end
      3:  c.adr = 1;
      4:  begin c.res = 1; c.regw = 1; end
      5:  begin c.adr = 1; c.memw = 1; end
      6:  begin c.srca = 2; c.alu = alu_ref(o, f3, f7); end
      7:  begin c.srca = 2; c.srcb = 1; c.alu = alu_ref(o, f3, f7); end
      8:  c.regw = 1;
      9:  begin c.srca = 2; c.alu = 1; c.pcw = z ? 1 : 0; end
      10: begin c.srca = 1; c.srcb = 2; c.pcw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic check_cycle(input string nm, input int s, input logic last);
    ctl_t c = expect_ctl(s, op, funct3, funct7b5, Zero, last);
    chk({nm, ".State"},     32'(State),      32'(s));
    chk({nm, ".PCWrite"},   32'(PCWrite),    32'(c.pcw));
    chk({nm, ".AdrSrc"},    32'(AdrSrc),     32'(c.adr));
    chk({nm, ".MemWrite"},  32'(MemWrite),   32'(c.memw));
    chk({nm, ".IRWrite"},   32'(IRWrite),    32'(c.irw));
    chk({nm, ".ResultSrc"}, 32'(ResultSrc),  32'(c.res));
    chk({nm, ".ALUSrcA"},   32'(ALUSrcA),    32'(c.srca));
    chk({nm, ".ALUSrcB"},   32'(ALUSrcB),    32'(c.srcb));
    chk({nm, ".RegWrite"},  32'(RegWrite),   32'(c.regw));
    chk({nm, ".ImmSrc"},    32'(ImmSrc),     32'(c.imm));
    chk({nm, ".ALUControl"},32'(ALUControl), 32'(c.alu));
    chk({nm, ".InstrDone"}, 32'(InstrDone),  32'(c.done));
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the last state.
  // zmode: 0/1 force Zero, 2 randomizes it every cycle.
  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode);
    int seq[$];
    int dones = 0;
    op = o; funct3 = f3; funct7b5 = f7;
    walk(o, seq);
    foreach (seq[i]) begin
      Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      check_cycle(nm, seq[i], i == seq.size() - 1);
      dones += int'(InstrDone);
      @(posedge clk); #1;
    end
    chk({nm, ".done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    logic [6:0] pool [7];
    reset = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b0;

    // Reset: enables low, FETCH selects visible.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.State",      32'(State),      32'd0);
    chk("rst.IRWrite",    32'(IRWrite),    32'd0);
    chk("rst.PCWrite",    32'(PCWrite),    32'd0);
    chk("rst.RegWrite",   32'(RegWrite),   32'd0);
    chk("rst.InstrDone",  32'(InstrDone),  32'd0);
    chk("rst.ALUSrcB",    32'(ALUSrcB),    32'd2);
    chk("rst.ResultSrc",  32'(ResultSrc),  32'd2);
    chk("rst.ALUControl", 32'(ALUControl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("sub",   RT, 3'b000, 1'b1, 2);
    run_instr("lw",    LW, 3'b010, 1'b0, 2);
    run_instr("sw",    SW, 3'b010, 1'b1, 2);
    run_instr("beq_z1", BQ, 3'b000, 1'b0, 1);
    run_instr("beq_z0", BQ, 3'b000, 1'b0, 0);
    run_instr("slti",  IT, 3'b010, 1'b0, 2);
    run_instr("ori",   IT, 3'b110, 1'b0, 2);
    run_instr("andi",  IT, 3'b111, 1'b0, 2);
    run_instr("addi7", IT, 3'b000, 1'b1, 2);
    run_instr("jal",   JL, 3'b000, 1'b0, 2);
    run_instr("ill",   7'b1111111, 3'b000, 1'b0, 2);

    // Abort a lw in MEMREAD: no writeback may follow.
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cycle("abort", i, 1'b0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort.rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("abort.rst_State",    32'(State),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.next_State",    32'(State),    32'd0);
    chk("abort.next_RegWrite", 32'(RegWrite), 32'd0);
    chk("abort.next_IRWrite",  32'(IRWrite),  32'd1);
    @(posedge clk); #1;
    // That cycle was a fresh FETCH; step through DECODE of the lw and let it finish.
    @(negedge clk);
    check_cycle("abort_dec", 1, 1'b0);
    @(posedge clk); #1;
    for (int s = 2; s <= 4; s++) begin
      @(negedge clk);
      check_cycle("abort_lw", s, s == 4);
      @(posedge clk); #1;
    end

    pool = '{LW, SW, RT, IT, BQ, JL, 7'b0};
    for (int n = 0; n < 80; n++) begin
      logic [6:0] o;
      int k = $urandom_range(0, 6);
      o = (k == 6) ? 7'($urandom) : pool[k];
      run_instr("rnd", o, 3'($urandom), 1'($urandom), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
